// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared constants for the simple-CPU datapath
//
// Purpose : bus-source indices (one per encoder_input bit), ALU opcode
//           encodings and IR field bit positions shared by datapath and ALU.
// Ports   : none (package).
package datapath_pkg;

   // Bus-source indices above the 16 GPRs; GPR Rn uses index n.
   localparam logic [4:0] SRC_HI     = 5'd16;
   localparam logic [4:0] SRC_LO     = 5'd17;
   localparam logic [4:0] SRC_ZHIGH  = 5'd18;
   localparam logic [4:0] SRC_ZLOW   = 5'd19;
   localparam logic [4:0] SRC_PC     = 5'd20;
   localparam logic [4:0] SRC_MDR    = 5'd21;
   localparam logic [4:0] SRC_INPORT = 5'd22;
   localparam logic [4:0] SRC_C      = 5'd23;

   typedef enum logic [4:0] {
      OP_ADD  = 5'b00011,
      OP_SUB  = 5'b00100,
      OP_AND  = 5'b00101,
      OP_OR   = 5'b00110,
      OP_ROR  = 5'b00111,
      OP_ROL  = 5'b01000,
      OP_SHR  = 5'b01001,
      OP_SHRA = 5'b01010,
      OP_SHL  = 5'b01011,
      OP_ADDI = 5'b01100,
      OP_ANDI = 5'b01101,
      OP_ORI  = 5'b01110,
      OP_DIV  = 5'b01111,
      OP_MUL  = 5'b10000,
      OP_NEG  = 5'b10001,
      OP_NOT  = 5'b10010
   } alu_op_e;

   // IR field positions
   localparam int IR_RA_MSB = 26;
   localparam int IR_RA_LSB = 23;
   localparam int IR_RB_MSB = 22;
   localparam int IR_RB_LSB = 19;
   localparam int IR_RC_MSB = 18;
   localparam int IR_RC_LSB = 15;
   localparam int IR_C2_MSB = 20;
   localparam int IR_C2_LSB = 19;
   localparam int IR_C_MSB  = 18;

   // mul and div are the only operations that also update HI/LO
   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/datapath_alu.sv
// rtl/datapath_alu.sv - combinational 32-bit ALU with 64-bit result
//
// Purpose : computes result from A (Y register) and B (bus) for the opcode.
// Ports   : a, b   in  32  operands
//           op     in  5   opcode (alu_op_e encoding)
//           result out 64  {Zhigh, Zlow}; Zhigh is 0 except for mul/div
module datapath_alu
   import datapath_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  op,
   output logic [63:0] result
);

   logic        [4:0]  shamt;
   logic        [5:0]  shamt_inv;
   logic signed [31:0] sa;
   logic signed [31:0] sb;
   logic signed [31:0] quot;
   logic signed [31:0] rem;
   logic        [63:0] prod;

   assign shamt     = b[4:0];
   // A shift by 32 yields 0, so a zero rotate count leaves a unchanged.
   assign shamt_inv = 6'd32 - {1'b0, shamt};
   assign sa        = a;
   assign sb        = b;
   assign quot      = sa / sb;
   assign rem       = sa % sb;
   // Low 64 bits of the product of the sign-extended operands is the signed product.
   assign prod      = {{32{a[31]}}, a} * {{32{b[31]}}, b};

   always_comb begin
      result = '0;
      case (op)
         OP_ADD, OP_ADDI: result[31:0] = a + b;
         OP_SUB:          result[31:0] = a - b;
         OP_AND, OP_ANDI: result[31:0] = a & b;
         OP_OR,  OP_ORI:  result[31:0] = a | b;
         OP_ROR:          result[31:0] = (a >> shamt) | (a << shamt_inv);
         OP_ROL:          result[31:0] = (a << shamt) | (a >> shamt_inv);
         OP_SHR:          result[31:0] = a >> shamt;
         OP_SHRA:         result[31:0] = $signed(a) >>> shamt;
         OP_SHL:          result[31:0] = a << shamt;
         OP_NEG:          result[31:0] = -b;
         OP_NOT:          result[31:0] = ~b;
         OP_DIV: begin
            if (b != 32'd0) begin
               result[31:0]  = quot;
               result[63:32] = rem;
            end
         end
         OP_MUL:          result = prod;
         default:         result = '0;
      endcase
   end

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - 32-bit bus-based datapath of the simple-CPU
//
// Purpose : GPRs, PC, IR, Y, Z, HI, LO, MAR, MDR, word memory, ALU,
//           select-and-encode logic, CON flip-flop and shared-bus encoder.
// Ports   : Clock, Resetn                 clock / async active-low reset
//           PCout..InPortout              bus-source strobes
//           MARin, Zin, PCin, MDRin,
//           IRin, Yin                     register load enables
//           IncPC, Read, Write, AND       PC increment, MDR source, mem write, force and
//           GRA, GRB, GRC, Rin, Rout,
//           BAout                         IR field select and GPR control
//           operation [4:0]               ALU opcode
//           Register_enable_Signals[15:0] direct GPR load enables
//           CON_in                        CON flip-flop load
//           encoder_input [31:0]          one-hot bus-source request vector
module datapath
   import datapath_pkg::*;
#(
   parameter int    MEM_WORDS = 512,
   parameter string MEM_INIT  = ""
)(
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        PCout,
   input  logic        Zlowout,
   input  logic        ZHighout,
   input  logic        MDRout,
   input  logic        HIout,
   input  logic        LOout,
   input  logic        Cout,
   input  logic        InPortout,
   input  logic        MARin,
   input  logic        Zin,
   input  logic        PCin,
   input  logic        MDRin,
   input  logic        IRin,
   input  logic        Yin,
   input  logic        IncPC,
   input  logic        Read,
   input  logic        Write,
   input  logic        AND,
   input  logic        GRA,
   input  logic        GRB,
   input  logic        GRC,
   input  logic        Rin,
   input  logic        Rout,
   input  logic        BAout,
   input  logic [4:0]  operation,
   input  logic [15:0] Register_enable_Signals,
   input  logic        CON_in,
   output logic [31:0] encoder_input
);

   localparam int AW = $clog2(MEM_WORDS);

   logic [31:0] gpr [16];
   logic [31:0] pc, ir, y, hi, lo, mar, mdr, in_port;
   logic [63:0] z;
   logic        con;
   logic [31:0] mem [MEM_WORDS];

   logic [31:0] bus;
   logic [4:0]  bus_sel;
   logic        bus_valid;
   logic [3:0]  field;
   logic [15:0] dec;
   logic [15:0] gpr_en;
   logic [15:0] gpr_out;
   logic [31:0] c_sext;
   logic [4:0]  alu_op;
   logic [63:0] alu_result;
   logic [AW-1:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        bus_zero;
   logic        con_next;
   logic        unused_bits;

   // Select-and-encode: IR register field chosen by GRA/GRB/GRC, then decoded.
   assign field   = ({4{GRA}} & ir[IR_RA_MSB:IR_RA_LSB])
                  | ({4{GRB}} & ir[IR_RB_MSB:IR_RB_LSB])
                  | ({4{GRC}} & ir[IR_RC_MSB:IR_RC_LSB]);
   assign dec     = 16'h0001 << field;
   assign gpr_en  = ({16{Rin}} & dec) | Register_enable_Signals;
   assign gpr_out = {16{Rout | BAout}} & dec;
   assign c_sext  = {{(31 - IR_C_MSB){ir[IR_C_MSB]}}, ir[IR_C_MSB:0]};

   assign encoder_input = {8'b0, Cout, InPortout, MDRout, PCout,
                           Zlowout, ZHighout, LOout, HIout, gpr_out};

   // Lowest set request bit owns the bus.
   always_comb begin
      bus_sel   = '0;
      bus_valid = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (encoder_input[i]) begin
            bus_sel   = 5'(i);
            bus_valid = 1'b1;
         end
      end
   end

   always_comb begin
      bus = '0;
      if (bus_valid) begin
         if (!bus_sel[4]) begin
            // R0 used as a base address reads as zero.
            bus = (bus_sel == 5'd0 && BAout) ? 32'd0 : gpr[bus_sel[3:0]];
         end else begin
            case (bus_sel)
               SRC_HI:     bus = hi;
               SRC_LO:     bus = lo;
               SRC_ZHIGH:  bus = z[63:32];
               SRC_ZLOW:   bus = z[31:0];
               SRC_PC:     bus = pc;
               SRC_MDR:    bus = mdr;
               SRC_INPORT: bus = in_port;
               SRC_C:      bus = c_sext;
               default:    bus = '0;
            endcase
         end
      end
   end

   assign alu_op = AND ? OP_AND : operation;

   datapath_alu u_alu (
      .a      (y),
      .b      (bus),
      .op     (alu_op),
      .result (alu_result)
   );

   assign mem_addr  = mar[AW-1:0];
   assign mem_rdata = mem[mem_addr];

   assign bus_zero = (bus == 32'd0);
   always_comb begin
      con_next = 1'b0;
      case (ir[IR_C2_MSB:IR_C2_LSB])
         2'b00: con_next = bus_zero;
         2'b01: con_next = !bus_zero;
         2'b10: con_next = !bus[31] && !bus_zero;
         2'b11: con_next = bus[31];
         default: con_next = 1'b0;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < 16; i++) gpr[i] <= '0;
         pc      <= '0;
         ir      <= '0;
         y       <= '0;
         z       <= '0;
         hi      <= '0;
         lo      <= '0;
         mar     <= '0;
         mdr     <= '0;
         in_port <= '0;
         con     <= 1'b0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (gpr_en[i]) gpr[i] <= bus;
         end
         if (PCin)  pc  <= IncPC ? pc + 32'd1 : bus;
         if (MARin) mar <= bus;
         if (Yin)   y   <= bus;
         if (IRin)  ir  <= bus;
         if (MDRin) mdr <= Read ? mem_rdata : bus;
         if (Zin) begin
            z <= alu_result;
            if (is_muldiv(alu_op)) begin
               hi <= alu_result[63:32];
               lo <= alu_result[31:0];
            end
         end
         if (CON_in) con <= con_next;
      end
   end

   // Memory is not reset; a read in the write cycle sees the old word.
   always_ff @(posedge Clock) begin
      if (Write) mem[mem_addr] <= mdr;
   end

   assign unused_bits = ^{mar[31:AW], ir[31:27], con};

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - self-checking bench for datapath
module tb_datapath;

   logic        Clock, Resetn;
   logic        PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout;
   logic        MARin, Zin, PCin, MDRin, IRin, Yin;
   logic        IncPC, Read, Write, AND;
   logic        GRA, GRB, GRC, Rin, Rout, BAout;
   logic [4:0]  operation;
   logic [15:0] Register_enable_Signals;
   logic        CON_in;
   logic [31:0] encoder_input;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [4:0]  op;
      logic        and_ovr;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] z;
   } alu_vec_t;

   typedef struct {
      logic [1:0]  c2;
      logic [31:0] val;
      logic        exp;
   } con_vec_t;

   alu_vec_t    avec [19];
   con_vec_t    cvec [7];
   logic [63:0] exp_q [$];
   logic [31:0] exp_hi, exp_lo;

   datapath dut (
      .Clock(Clock), .Resetn(Resetn),
      .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
      .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .IncPC(IncPC), .Read(Read), .Write(Write), .AND(AND),
      .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .operation(operation), .Register_enable_Signals(Register_enable_Signals),
      .CON_in(CON_in), .encoder_input(encoder_input)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      PCout = 0; Zlowout = 0; ZHighout = 0; MDRout = 0; HIout = 0; LOout = 0;
      Cout = 0; InPortout = 0; MARin = 0; Zin = 0; PCin = 0; MDRin = 0;
      IRin = 0; Yin = 0; IncPC = 0; Read = 0; Write = 0; AND = 0;
      GRA = 0; GRB = 0; GRC = 0; Rin = 0; Rout = 0; BAout = 0;
      operation = 5'd0; Register_enable_Signals = 16'd0; CON_in = 0;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Bench-side preload of a memory word, then pulled into MDR via Read.
   task automatic poke(input int addr, input logic [31:0] val);
      dut.mem[addr] = val;
      Read = 1; MDRin = 1;
      tick();
      idle();
   endtask

   task automatic mdr_to_ir(input logic [31:0] val);
      poke(0, val);
      MDRout = 1; IRin = 1;
      tick();
      idle();
   endtask

   initial begin
      avec[0]  = '{5'b00011, 1'b0, 32'h7FFFFFFF, 32'h00000001, 64'h00000000_80000000};
      avec[1]  = '{5'b00100, 1'b0, 32'h00000005, 32'h00000007, 64'h00000000_FFFFFFFE};
      avec[2]  = '{5'b00101, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000};
      avec[3]  = '{5'b00110, 1'b0, 32'hF0F0F0F0, 32'h0F000F00, 64'h00000000_FFF0FFF0};
      avec[4]  = '{5'b00111, 1'b0, 32'h00000001, 32'h00000001, 64'h00000000_80000000};
      avec[5]  = '{5'b01000, 1'b0, 32'h80000001, 32'h00000004, 64'h00000000_00000018};
      avec[6]  = '{5'b01001, 1'b0, 32'h80000000, 32'h0000001F, 64'h00000000_00000001};
      avec[7]  = '{5'b01010, 1'b0, 32'h80000000, 32'h00000004, 64'h00000000_F8000000};
      avec[8]  = '{5'b01011, 1'b0, 32'h00000003, 32'h00000021, 64'h00000000_00000006};
      avec[9]  = '{5'b10001, 1'b0, 32'h12345678, 32'h00000005, 64'h00000000_FFFFFFFB};
      avec[10] = '{5'b10010, 1'b0, 32'h00000000, 32'h0000FFFF, 64'h00000000_FFFF0000};
      avec[11] = '{5'b10000, 1'b0, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA};
      avec[12] = '{5'b01111, 1'b0, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
      avec[13] = '{5'b00011, 1'b0, 32'h00000010, 32'h00000020, 64'h00000000_00000030};
      avec[14] = '{5'b01111, 1'b0, 32'h00000007, 32'h00000000, 64'h00000000_00000000};
      avec[15] = '{5'b00000, 1'b0, 32'h00000001, 32'h00000002, 64'h00000000_00000000};
      avec[16] = '{5'b01100, 1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_00000000};
      avec[17] = '{5'b00111, 1'b0, 32'h12345678, 32'h00000020, 64'h00000000_12345678};
      avec[18] = '{5'b00011, 1'b1, 32'h0000000C, 32'h0000000A, 64'h00000000_00000008};

      cvec[0] = '{2'b01, 32'h00000005, 1'b1};
      cvec[1] = '{2'b00, 32'h00000005, 1'b0};
      cvec[2] = '{2'b00, 32'h00000000, 1'b1};
      cvec[3] = '{2'b10, 32'h80000000, 1'b0};
      cvec[4] = '{2'b10, 32'h00000007, 1'b1};
      cvec[5] = '{2'b11, 32'h80000000, 1'b1};
      cvec[6] = '{2'b01, 32'h00000000, 1'b0};

      idle();
      Resetn = 0;
      repeat (2) @(posedge Clock);
      #1;
      check("reset_pc", dut.pc, 0);
      check("reset_z", dut.z, 0);
      check("reset_enc", encoder_input, 0);
      check("reset_bus", dut.bus, 0);
      Resetn = 1;
      tick();

      // Fetch
      dut.mem[0] = 32'h0A2FFFFD;
      PCout = 1; MARin = 1; IncPC = 1;
      #1;
      check("fetch_enc_pc", encoder_input, 32'h00100000);
      tick(); idle();
      check("fetch_mar", dut.mar, 0);
      PCin = 1; IncPC = 1; Read = 1; MDRin = 1;
      tick(); idle();
      check("fetch_pc", dut.pc, 1);
      MDRout = 1; IRin = 1;
      #1;
      check("fetch_enc_mdr", encoder_input, 32'h00200000);
      tick(); idle();
      check("fetch_ir", dut.ir, 32'h0A2FFFFD);

      // Encoder priority
      PCout = 1; MDRout = 1;
      #1;
      check("prio_enc", encoder_input, 32'h00300000);
      check("prio_bus", dut.bus, 1);
      tick(); idle();

      // ldi R4, 0x54(R0)
      poke(0, 32'h11111111);
      MDRout = 1; Register_enable_Signals = 16'h0001;
      tick(); idle();
      mdr_to_ir(32'h0A000054);
      GRB = 1; Rout = 1;
      #1;
      check("r0_rout_bus", dut.bus, 32'h11111111);
      tick(); idle();
      GRB = 1; BAout = 1; Yin = 1;
      #1;
      check("r0_baout_enc", encoder_input, 32'h00000001);
      check("r0_baout_bus", dut.bus, 0);
      tick(); idle();
      check("ldi_y", dut.y, 0);
      Cout = 1; operation = 5'b00011; Zin = 1;
      tick(); idle();
      check("ldi_zlow", dut.z, 64'h54);
      Zlowout = 1; GRA = 1; Rin = 1;
      tick(); idle();
      check("ldi_r4", dut.gpr[4], 32'h54);
      check("ldi_r0", dut.gpr[0], 32'h11111111);

      // ALU vectors through the scoreboard
      exp_hi = 0; exp_lo = 0;
      for (int i = 0; i < 19; i++) begin
         poke(0, avec[i].a);
         MDRout = 1; Yin = 1;
         tick(); idle();
         poke(0, avec[i].b);
         MDRout = 1; operation = avec[i].op; AND = avec[i].and_ovr; Zin = 1;
         exp_q.push_back(avec[i].z);
         if (!avec[i].and_ovr && (avec[i].op == 5'b10000 || avec[i].op == 5'b01111)) begin
            exp_hi = avec[i].z[63:32];
            exp_lo = avec[i].z[31:0];
         end
         tick(); idle();
         if (exp_q.size() == 0) begin
            check($sformatf("alu%0d_sb_empty", i), 1, 0);
         end else begin
            check($sformatf("alu%0d_z", i), dut.z, exp_q.pop_front());
         end
         check($sformatf("alu%0d_hi", i), dut.hi, exp_hi);
         check($sformatf("alu%0d_lo", i), dut.lo, exp_lo);
      end

      // CON
      for (int i = 0; i < 7; i++) begin
         mdr_to_ir(32'(cvec[i].c2) << 19);
         poke(0, cvec[i].val);
         MDRout = 1; CON_in = 1;
         tick(); idle();
         check($sformatf("con%0d", i), dut.con, cvec[i].exp);
      end
      poke(0, 32'h00000005);
      MDRout = 1;
      tick(); idle();
      check("con_hold", dut.con, 0);

      // Memory write / read-back at address 9
      mdr_to_ir(32'h00800000);
      poke(0, 32'd9);
      MDRout = 1; Register_enable_Signals = 16'h0002;
      tick(); idle();
      poke(0, 32'hDEADBEEF);
      dut.mem[9] = 32'h0;
      GRA = 1; Rout = 1; MARin = 1;
      tick(); idle();
      check("mem_mar", dut.mar, 9);
      Write = 1; Read = 1; MDRin = 1;
      tick(); idle();
      check("mem_read_old", dut.mdr, 0);
      check("mem_written", dut.mem[9], 32'hDEADBEEF);
      Read = 1; MDRin = 1;
      tick(); idle();
      check("mem_readback", dut.mdr, 32'hDEADBEEF);

      // Asynchronous reset between clock edges
      Resetn = 0;
      #2;
      check("areset_pc", dut.pc, 0);
      check("areset_ir", dut.ir, 0);
      check("areset_z", dut.z, 0);
      check("areset_r4", dut.gpr[4], 0);
      check("areset_r1", dut.gpr[1], 0);
      check("areset_mar", dut.mar, 0);
      check("areset_mem_kept", dut.mem[9], 32'hDEADBEEF);
      tick();
      Resetn = 1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
